// File: rtl/fm_weight_reader.sv
// fm_weight_reader: sequential read master for the parameter flash.
// On start, reads the 326-word image (8 hidden records of 37 words, then
// 10 output records of 3 words) one word at a time. Each word is presented
// on a valid/ready stream, tagged with its layer, neuron index and kind.
//
// Optional feature macro: FM_NIBBLE_UNPACK_EN. When it is defined, each
// weight word is split into four signed 4-bit beats (bits [15:12] first),
// and each beat is sign-extended to 16 bits. Biases stay as one 16-bit beat.
//
// Ports:
//   clk, n_rst         clock, asynchronous active-low reset
//   start              load request, honoured only when idle
//   fm_ce/fm_oe/fm_we  flash controls (fm_we is tied low)
//   fm_address         flash word address
//   fm_data            flash read data
//   out_data           parameter beat
//   out_is_bias        1 = bias, 0 = weight
//   out_layer          0 = hidden, 1 = output
//   out_neuron         global neuron index (0..17)
//   out_valid/ready    stream handshake
//   out_last           final beat of the image
//   busy               high from start acceptance through the last beat
//   done               one-cycle pulse after the last beat is accepted
module fm_weight_reader #(
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  output logic        fm_ce,
  output logic        fm_oe,
  output logic        fm_we,
  output logic [15:0] fm_address,
  input  logic [15:0] fm_data,
  output logic [15:0] out_data,
  output logic        out_is_bias,
  output logic        out_layer,
  output logic [4:0]  out_neuron,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  localparam int unsigned AW           = 16;
  localparam int unsigned OFF_W        = 9;
  localparam int unsigned POS_W        = 6;
  localparam int unsigned NEU_W        = 5;
  localparam int unsigned WAIT_W       = 4;
  localparam int unsigned LAST_OFFSET  = 325;
  localparam int unsigned HID_LAST_POS = 36;
  localparam int unsigned OUT_LAST_POS = 2;
  localparam int unsigned HID_NEURONS  = 8;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ACCESS  = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]       state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic [OFF_W-1:0] offset, offset_nxt;
  logic [POS_W-1:0] pos, pos_nxt;
  logic [NEU_W-1:0] neuron, neuron_nxt;
  logic [15:0]      word_q, word_q_nxt;
  logic             fm_ce_nxt, fm_oe_nxt;
  logic [AW-1:0]    fm_address_nxt;
  logic [15:0]      out_data_nxt;
  logic             out_is_bias_nxt, out_layer_nxt, out_valid_nxt, out_last_nxt;
  logic [4:0]       out_neuron_nxt;
  logic             busy_nxt, done_nxt;

  logic             hidden, rec_last, last_word;
  logic [OFF_W-1:0] offset_inc;

  assign fm_we      = 1'b0;
  assign hidden     = neuron < NEU_W'(HID_NEURONS);
  assign rec_last   = hidden ? (pos == POS_W'(HID_LAST_POS)) : (pos == POS_W'(OUT_LAST_POS));
  assign last_word  = offset == OFF_W'(LAST_OFFSET);
  assign offset_inc = offset + OFF_W'(1);

`ifdef FM_NIBBLE_UNPACK_EN
  logic [1:0] nib_cnt, nib_cnt_nxt;

  // Selected nibble of a weight word, sign-extended to 16 bits.
  function automatic logic [15:0] nib_sext(input logic [15:0] w, input logic [1:0] idx);
    logic [3:0] n;
    case (idx)
      2'd0:    n = w[15:12];
      2'd1:    n = w[11:8];
      2'd2:    n = w[7:4];
      default: n = w[3:0];
    endcase
    return {{12{n[3]}}, n};
  endfunction
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_nxt       = state;
    wait_cnt_nxt    = wait_cnt;
    offset_nxt      = offset;
    pos_nxt         = pos;
    neuron_nxt      = neuron;
    word_q_nxt      = word_q;
    fm_ce_nxt       = fm_ce;
    fm_oe_nxt       = fm_oe;
    fm_address_nxt  = fm_address;
    out_data_nxt    = out_data;
    out_is_bias_nxt = out_is_bias;
    out_layer_nxt   = out_layer;
    out_neuron_nxt  = out_neuron;
    out_valid_nxt   = out_valid;
    out_last_nxt    = out_last;
    busy_nxt        = busy;
    done_nxt        = 1'b0;
`ifdef FM_NIBBLE_UNPACK_EN
    nib_cnt_nxt     = nib_cnt;
`endif

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt      = S_ACCESS;
          wait_cnt_nxt   = '0;
          offset_nxt     = '0;
          pos_nxt        = '0;
          neuron_nxt     = '0;
          fm_ce_nxt      = 1'b1;
          fm_oe_nxt      = 1'b1;
          fm_address_nxt = AW'(BASE_ADDR);
          busy_nxt       = 1'b1;
        end
      end

      S_ACCESS: begin
        // Data is sampled on the edge that ends the last wait cycle.
        if (wait_cnt == WAIT_W'(WAIT_CYCLES)) begin
          state_nxt  = S_CAPTURE;
          word_q_nxt = fm_data;
          fm_ce_nxt  = 1'b0;
          fm_oe_nxt  = 1'b0;
        end else begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end

      S_CAPTURE: begin
        state_nxt       = S_PRESENT;
        out_valid_nxt   = 1'b1;
        out_is_bias_nxt = pos == '0;
        out_layer_nxt   = !hidden;
        out_neuron_nxt  = neuron;
`ifdef FM_NIBBLE_UNPACK_EN
        nib_cnt_nxt     = '0;
        out_data_nxt    = (pos == '0) ? word_q : nib_sext(word_q, 2'd0);
        out_last_nxt    = last_word && (pos == '0);
`else
        out_data_nxt    = word_q;
        out_last_nxt    = last_word;
`endif
      end

      S_PRESENT: begin
        if (out_ready) begin
`ifdef FM_NIBBLE_UNPACK_EN
          if (!out_is_bias && nib_cnt != 2'd3) begin
            // Remaining nibbles of the same word need no new flash read.
            nib_cnt_nxt  = nib_cnt + 2'd1;
            out_data_nxt = nib_sext(word_q, nib_cnt + 2'd1);
            out_last_nxt = last_word && (nib_cnt == 2'd2);
          end else
`endif
          begin
            out_valid_nxt = 1'b0;
            out_last_nxt  = 1'b0;
            if (last_word) begin
              state_nxt = S_DONE;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
            end else begin
              state_nxt      = S_ACCESS;
              wait_cnt_nxt   = '0;
              offset_nxt     = offset_inc;
              fm_ce_nxt      = 1'b1;
              fm_oe_nxt      = 1'b1;
              fm_address_nxt = AW'(BASE_ADDR) + AW'(offset_inc);
              if (rec_last) begin
                pos_nxt    = '0;
                neuron_nxt = neuron + NEU_W'(1);
              end else begin
                pos_nxt = pos + POS_W'(1);
              end
            end
          end
        end
      end

      S_DONE: state_nxt = S_IDLE;

      default: state_nxt = S_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      offset      <= '0;
      pos         <= '0;
      neuron      <= '0;
      word_q      <= '0;
      fm_ce       <= 1'b0;
      fm_oe       <= 1'b0;
      fm_address  <= AW'(BASE_ADDR);
      out_data    <= '0;
      out_is_bias <= 1'b0;
      out_layer   <= 1'b0;
      out_neuron  <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef FM_NIBBLE_UNPACK_EN
      nib_cnt     <= '0;
`endif
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      offset      <= offset_nxt;
      pos         <= pos_nxt;
      neuron      <= neuron_nxt;
      word_q      <= word_q_nxt;
      fm_ce       <= fm_ce_nxt;
      fm_oe       <= fm_oe_nxt;
      fm_address  <= fm_address_nxt;
      out_data    <= out_data_nxt;
      out_is_bias <= out_is_bias_nxt;
      out_layer   <= out_layer_nxt;
      out_neuron  <= out_neuron_nxt;
      out_valid   <= out_valid_nxt;
      out_last    <= out_last_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
`ifdef FM_NIBBLE_UNPACK_EN
      nib_cnt     <= nib_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_fm_weight_reader.sv
// Scoreboard bench for fm_weight_reader: the flash model returns its
// address as data, stimulus queues the expected beats, a monitor checks.
module tb_fm_weight_reader;

  localparam int unsigned BASE   = 0;
  localparam int unsigned WAITC  = 2;
  localparam int unsigned NWORDS = 326;
`ifdef FM_NIBBLE_UNPACK_EN
  localparam int unsigned NBEATS = 1250;
`else
  localparam int unsigned NBEATS = 326;
`endif

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic        out_ready = 1'b1;
  logic        fm_ce, fm_oe, fm_we;
  logic [15:0] fm_address, fm_data, out_data;
  logic        out_is_bias, out_layer, out_valid, out_last, busy, done;
  logic [4:0]  out_neuron;

  fm_weight_reader #(.BASE_ADDR(BASE), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .n_rst(n_rst), .start(start),
    .fm_ce(fm_ce), .fm_oe(fm_oe), .fm_we(fm_we),
    .fm_address(fm_address), .fm_data(fm_data),
    .out_data(out_data), .out_is_bias(out_is_bias), .out_layer(out_layer),
    .out_neuron(out_neuron), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Flash model: data is only meaningful while selected.
  assign fm_data = (fm_ce && fm_oe) ? fm_address : 16'hDEAD;

  typedef struct packed {
    logic [15:0] data;
    logic        is_bias;
    logic        layer;
    logic [4:0]  neuron;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int n_accept = 0;
  int done_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  // Expected beats of the whole image, derived from the record layout.
  task automatic push_image();
    beat_t b;
    int neu, pos;
    for (int o = 0; o < int'(NWORDS); o++) begin
      if (o < 296) begin
        neu = o / 37;
        pos = o % 37;
      end else begin
        neu = 8 + (o - 296) / 3;
        pos = (o - 296) % 3;
      end
      b.is_bias = (pos == 0);
      b.layer   = (o >= 296);
      b.neuron  = 5'(neu);
`ifdef FM_NIBBLE_UNPACK_EN
      if (pos == 0) begin
        b.data = 16'(BASE + o);
        b.last = 1'b0;
        exp_q.push_back(b);
      end else begin
        for (int k = 0; k < 4; k++) begin
          logic [15:0] w;
          logic [3:0]  n;
          w = 16'(BASE + o);
          n = 4'(w >> (12 - 4 * k));
          b.data = {{12{n[3]}}, n};
          b.last = (o == 325) && (k == 3);
          exp_q.push_back(b);
        end
      end
`else
      b.data = 16'(BASE + o);
      b.last = (o == 325);
      exp_q.push_back(b);
`endif
    end
  endtask

  // Monitor: compare every accepted beat against the scoreboard.
  always @(negedge clk) begin
    if (n_rst && done) done_count++;
    if (n_rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_beat", 32'(exp_q.size()), 32'd1);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("data", 32'(out_data), 32'(e.data));
        check("is_bias", 32'(out_is_bias), 32'(e.is_bias));
        check("layer", 32'(out_layer), 32'(e.layer));
        check("neuron", 32'(out_neuron), 32'(e.neuron));
        check("last", 32'(out_last), 32'(e.last));
`ifndef FM_NIBBLE_UNPACK_EN
        case (out_data)
          16'd36:  begin check("b36_bias", 32'(out_is_bias), 0); check("b36_neu", 32'(out_neuron), 0); end
          16'd37:  begin check("b37_bias", 32'(out_is_bias), 1); check("b37_neu", 32'(out_neuron), 1);
                         check("b37_layer", 32'(out_layer), 0); end
          16'd296: begin check("b296_bias", 32'(out_is_bias), 1); check("b296_neu", 32'(out_neuron), 8);
                         check("b296_layer", 32'(out_layer), 1); end
          16'd325: begin check("b325_bias", 32'(out_is_bias), 0); check("b325_neu", 32'(out_neuron), 17);
                         check("b325_last", 32'(out_last), 1); end
          default: ;
        endcase
`endif
      end
      n_accept++;
    end
  end

  task automatic reset_values(input string tag);
    check({tag, "_ce"}, 32'(fm_ce), 0);
    check({tag, "_oe"}, 32'(fm_oe), 0);
    check({tag, "_we"}, 32'(fm_we), 0);
    check({tag, "_addr"}, 32'(fm_address), BASE);
    check({tag, "_valid"}, 32'(out_valid), 0);
    check({tag, "_last"}, 32'(out_last), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_data"}, 32'(out_data), 0);
    check({tag, "_bias"}, 32'(out_is_bias), 0);
    check({tag, "_layer"}, 32'(out_layer), 0);
    check({tag, "_neuron"}, 32'(out_neuron), 0);
  endtask

  // Pulse start (caller is at posedge+1), then check first-beat latency.
  task automatic issue_start();
    int lat;
    n_accept = 0;
    push_image();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_busy", 32'(busy), 1);
    check("start_ce", 32'(fm_ce && fm_oe), 1);
    check("start_addr", 32'(fm_address), BASE);
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("first_latency", 32'(lat), WAITC + 3);
  endtask

  task automatic wait_done(input int exp_done);
    int c = 0;
    while (!done && c < 20000) begin
      @(posedge clk); #1;
      c++;
    end
    check("done_seen", 32'(done), 1);
    check("busy_at_done", 32'(busy), 0);
    check("queue_empty", 32'(exp_q.size()), 0);
    check("beat_count", 32'(n_accept), NBEATS);
    @(posedge clk); #1;
    check("done_pulse_width", 32'(done), 0);
    check("done_count", 32'(done_count), 32'(exp_done));
  endtask

  task automatic wait_beat(input int idx);
    int c = 0;
    while (!(out_valid && n_accept == idx) && c < 20000) begin
      @(posedge clk); #1;
      c++;
    end
    check("reach_beat", 32'(n_accept), 32'(idx));
  endtask

  initial begin
    logic [15:0] hold_data, hold_addr;
    logic [4:0]  hold_neu;

    repeat (3) @(posedge clk);
    #1;
    reset_values("reset");
    n_rst = 1'b1;
    @(posedge clk); #1;

    // Plain full run.
    issue_start();
    wait_done(1);

    // Backpressure on beat 3, then a start pulse while busy.
    issue_start();
    wait_beat(3);
    out_ready = 1'b0;
    hold_data = out_data;
    hold_addr = fm_address;
    hold_neu  = out_neuron;
    repeat (7) begin
      @(posedge clk); #1;
      check("bp_valid", 32'(out_valid), 1);
      check("bp_data", 32'(out_data), 32'(hold_data));
      check("bp_neuron", 32'(out_neuron), 32'(hold_neu));
      check("bp_ce", 32'(fm_ce), 0);
      check("bp_addr", 32'(fm_address), 32'(hold_addr));
    end
    out_ready = 1'b1;
    wait_beat(100);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(2);

    // Reset in the middle of a run.
    issue_start();
    wait_beat(50);
    n_rst = 1'b0;
    #1;
    reset_values("midrst");
    exp_q.delete();
    repeat (5) @(posedge clk);
    #1;
    check("midrst_done_count", 32'(done_count), 2);
    reset_values("midrst_hold");
    n_rst = 1'b1;
    @(posedge clk); #1;

    // Clean run after the aborted one.
    issue_start();
    wait_done(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
